// File: rtl/bar_move_scheduler.sv
// bar_move_scheduler: tracks held bar keys from PS/2 make/break events and
// issues one move step per handshake, round-robin between the two bars,
// once per frame tick.
// Optional build macro HOLD_TIMEOUT_EN: held keys self-clear after HOLD_TO
// ticks without a fresh make code.
module bar_move_scheduler #(
    parameter int unsigned TICK_DIV = 833333,
    parameter int unsigned CNT_W    = 20,
    parameter logic [7:0]  L_UP     = 8'h1D,
    parameter logic [7:0]  L_DN     = 8'h1B,
    parameter logic [7:0]  L_LT     = 8'h1C,
    parameter logic [7:0]  L_RT     = 8'h23,
    parameter logic [7:0]  R_UP     = 8'd146,
    parameter logic [7:0]  R_DN     = 8'd147,
    parameter logic [7:0]  R_LT     = 8'd145,
    parameter logic [7:0]  R_RT     = 8'd144,
    parameter int unsigned HOLD_TO  = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       code_valid,
    input  logic [7:0] scancode,
    input  logic       released,
    output logic       upd_valid,
    input  logic       upd_ready,
    output logic       upd_player,
    output logic [1:0] upd_dir,
    output logic [3:0] held_l,
    output logic [3:0] held_r,
    output logic       overrun
);

    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             w_tick;
    logic [7:0]       r_held;
    logic [7:0]       w_hit;
    logic [3:0]       r_pend_l, r_pend_r;
    logic [3:0]       w_snap_l, w_snap_r;
    logic             r_rr, r_overrun;
    logic             w_sel;
    logic [3:0]       w_sel_mask, w_sel_onehot;
    logic [1:0]       w_sel_dir;
    logic [3:0]       w_clr_l, w_clr_r;
    logic             w_accept, w_last;

    // Opposing directions cancel as pairs: up/down and left/right.
    function automatic logic [3:0] cancel_pairs(input logic [3:0] m);
        return m & ~{{2{m[3] & m[2]}}, {2{m[1] & m[0]}}};
    endfunction

    assign w_tick = (r_cnt == CNT_W'(TICK_DIV - 1));

    // Free-running move tick divider, wraps at TICK_DIV-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_cnt <= '0;
        else     r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
    end

    // Held bitmap layout: [7:4] left bar, [3:0] right bar, each {up,down,left,right}.
    assign w_hit = {8{code_valid}} & {scancode == L_UP, scancode == L_DN,
                                      scancode == L_LT, scancode == L_RT,
                                      scancode == R_UP, scancode == R_DN,
                                      scancode == R_LT, scancode == R_RT};

`ifdef HOLD_TIMEOUT_EN
    localparam int unsigned AGE_W = $clog2(HOLD_TO + 1);

    logic [AGE_W-1:0] r_age [8];

    // Make/break events set/clear held bits; each tick ages set bits and drops stale ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_held <= '0;
            for (int i = 0; i < 8; i++) r_age[i] <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (w_hit[i]) begin
                    r_held[i] <= ~released;
                    r_age[i]  <= '0;
                end else if (w_tick && r_held[i]) begin
                    if (r_age[i] == AGE_W'(HOLD_TO - 1)) begin
                        r_held[i] <= 1'b0;
                        r_age[i]  <= '0;
                    end else begin
                        r_age[i]  <= r_age[i] + 1'b1;
                    end
                end
            end
        end
    end
`else
    // Make/break events set/clear held bits; nothing else touches them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_held <= '0;
        else     r_held <= (r_held & ~w_hit) | (w_hit & {8{~released}});
    end
`endif

    assign held_l   = r_held[7:4];
    assign held_r   = r_held[3:0];
    assign w_snap_l = cancel_pairs(r_held[7:4]);
    assign w_snap_r = cancel_pairs(r_held[3:0]);

    // Round-robin bar choice falls to the other bar when the favoured one has nothing left.
    assign w_sel        = (r_rr ? (r_pend_r != 4'd0) : (r_pend_l != 4'd0)) ? r_rr : ~r_rr;
    assign w_sel_mask   = w_sel ? r_pend_r : r_pend_l;
    assign w_sel_dir    = w_sel_mask[3] ? 2'd0 : w_sel_mask[2] ? 2'd1 : w_sel_mask[1] ? 2'd2 : 2'd3;
    assign w_sel_onehot = 4'b1000 >> w_sel_dir;
    assign w_clr_l      = w_sel ? 4'd0 : w_sel_onehot;
    assign w_clr_r      = w_sel ? w_sel_onehot : 4'd0;
    assign w_accept     = (r_state == S_ISSUE) && upd_ready;
    assign w_last       = ((r_pend_l & ~w_clr_l) | (r_pend_r & ~w_clr_r)) == 4'd0;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // FSM next state: start a burst on a tick with work, end it on the final accept.
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == S_IDLE) w_state_nxt = (w_tick && (w_snap_l | w_snap_r) != 4'd0) ? S_ISSUE : S_IDLE;
        else                   w_state_nxt = (w_accept && w_last) ? S_IDLE : S_ISSUE;
    end

    // FSM outputs: the request fields are forced to zero whenever no request is offered.
    always_comb begin
        upd_valid  = (r_state == S_ISSUE);
        upd_player = upd_valid & w_sel;
        upd_dir    = upd_valid ? w_sel_dir : 2'd0;
    end

    // Pending snapshot, round-robin pointer and sticky overrun flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_l  <= '0;
            r_pend_r  <= '0;
            r_rr      <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_tick) begin
                r_pend_l <= w_snap_l;
                r_pend_r <= w_snap_r;
            end else if (w_accept) begin
                r_pend_l <= r_pend_l & ~w_clr_l;
                r_pend_r <= r_pend_r & ~w_clr_r;
                r_rr     <= ~w_sel;
            end
            if (r_state == S_ISSUE && w_tick) r_overrun <= 1'b1;
        end
    end

    assign overrun = r_overrun;

endmodule

// File: tb/tb_bar_move_scheduler.sv
// tb_bar_move_scheduler: directed and random stimulus against a behavioural model of the scheduler.
module tb_bar_move_scheduler;
    localparam int TD = 16;
    localparam int HT = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       code_valid = 1'b0;
    logic [7:0] scancode = 8'd0;
    logic       released = 1'b0;
    logic       upd_ready = 1'b0;
    logic       upd_valid, upd_player, overrun;
    logic [1:0] upd_dir;
    logic [3:0] held_l, held_r;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    bar_move_scheduler #(.TICK_DIV(TD), .CNT_W(4), .HOLD_TO(HT)) dut (
        .clk(clk), .rst(rst), .code_valid(code_valid), .scancode(scancode),
        .released(released), .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_player(upd_player), .upd_dir(upd_dir), .held_l(held_l),
        .held_r(held_r), .overrun(overrun)
    );

    // Key table indexed [player][direction code]: 0 up, 1 down, 2 left, 3 right.
    logic [7:0] keys [2][4] = '{'{8'h1D, 8'h1B, 8'h1C, 8'h23},
                                '{8'd146, 8'd147, 8'd145, 8'd144}};

    bit m_held [2][4];
    bit m_pend [2][4];
    int m_age  [2][4];
    int m_rr, m_cnt;
    bit m_busy, m_ovr;

    task automatic model_reset();
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < 4; k++) begin
                m_held[p][k] = 0;
                m_pend[p][k] = 0;
                m_age[p][k]  = 0;
            end
        m_rr = 0; m_cnt = 0; m_busy = 0; m_ovr = 0;
    endtask

    function automatic bit any_pend(input int p);
        for (int k = 0; k < 4; k++) if (m_pend[p][k]) return 1;
        return 0;
    endfunction

    function automatic logic [3:0] bitmap(input int p);
        return {m_held[p][0], m_held[p][1], m_held[p][2], m_held[p][3]};
    endfunction

    task automatic sel(output int p, output int d);
        p = any_pend(m_rr) ? m_rr : 1 - m_rr;
        d = 0;
        for (int k = 3; k >= 0; k--) if (m_pend[p][k]) d = k;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic check_all();
        int p, d;
        p = 0; d = 0;
        if (m_busy) sel(p, d);
        chk("upd_valid",  8'(upd_valid),  8'(m_busy));
        chk("upd_player", 8'(upd_player), m_busy ? 8'(p) : 8'd0);
        chk("upd_dir",    8'(upd_dir),    m_busy ? 8'(d) : 8'd0);
        chk("held_l",     8'(held_l),     8'(bitmap(0)));
        chk("held_r",     8'(held_r),     8'(bitmap(1)));
        chk("overrun",    8'(overrun),    8'(m_ovr));
    endtask

    // Advance the model by one clock using the inputs currently driven, then clock the DUT and compare.
    task automatic step();
        int  p, d;
        bit  tick, keep;
        tick = (m_cnt == TD - 1);
        if (m_busy) begin
            sel(p, d);
            if (tick) m_ovr = 1;
            if (upd_ready) begin
                m_pend[p][d] = 0;
                m_rr = 1 - p;
                m_busy = any_pend(0) || any_pend(1);
            end
        end else if (tick) begin
            for (int q = 0; q < 2; q++)
                for (int k = 0; k < 4; k++) begin
                    keep = m_held[q][k] && !m_held[q][k ^ 1];
                    m_pend[q][k] = keep;
                    if (keep) m_busy = 1;
                end
        end
        for (int q = 0; q < 2; q++)
            for (int k = 0; k < 4; k++) begin
                if (code_valid && scancode == keys[q][k]) begin
                    m_held[q][k] = !released;
                    m_age[q][k]  = 0;
                end
`ifdef HOLD_TIMEOUT_EN
                else if (tick && m_held[q][k]) begin
                    m_age[q][k]++;
                    if (m_age[q][k] == HT) begin
                        m_held[q][k] = 0;
                        m_age[q][k]  = 0;
                    end
                end
`endif
            end
        m_cnt = (m_cnt + 1) % TD;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic key(input logic [7:0] c, input logic rel);
        code_valid = 1'b1;
        scancode   = c;
        released   = rel;
        step();
        code_valid = 1'b0;
        released   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        // Single right-bar up key, then its break.
        upd_ready = 1'b1;
        key(8'd146, 1'b0);
        run(40);
        key(8'd146, 1'b1);
        run(40);

        // One key per bar: left up then right right, each tick.
        key(8'h1D, 1'b0);
        key(8'd144, 1'b0);
        run(50);
        key(8'h1D, 1'b1);
        key(8'd144, 1'b1);
        run(20);

        // Cancelled pair, then a surviving third direction.
        key(8'h1D, 1'b0);
        key(8'h1B, 1'b0);
        run(40);
        key(8'h1C, 1'b0);
        run(40);
        key(8'h1D, 1'b1);
        key(8'h1B, 1'b1);
        key(8'h1C, 1'b1);
        run(20);

        // Back-pressure across several ticks raises overrun.
        upd_ready = 1'b0;
        key(8'h23, 1'b0);
        run(40);
        upd_ready = 1'b1;
        run(20);
        key(8'h23, 1'b1);
        run(20);

        // Asynchronous reset while a request is outstanding.
        upd_ready = 1'b0;
        key(8'd146, 1'b0);
        for (int i = 0; i < 40 && !upd_valid; i++) step();
        chk("reach_valid", 8'(upd_valid), 8'd1);
        do_reset();
        upd_ready = 1'b1;
        run(60);

        // Random key traffic and back-pressure.
        repeat (1500) begin
            code_valid = ($urandom_range(0, 3) == 0);
            scancode   = ($urandom_range(0, 4) == 0) ? 8'($urandom) : keys[$urandom_range(0, 1)][$urandom_range(0, 3)];
            released   = ($urandom_range(0, 9) < 4);
            upd_ready  = ($urandom_range(0, 2) != 0);
            step();
        end
        code_valid = 1'b0;
        released   = 1'b0;

`ifdef HOLD_TIMEOUT_EN
        // Held key ages out; a repeat make restarts its age.
        do_reset();
        upd_ready = 1'b1;
        key(8'h1D, 1'b0);
        run(TD * 8);
        do_reset();
        key(8'h1D, 1'b0);
        run(TD * 4);
        key(8'h1D, 1'b0);
        run(TD * 8);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/bar_move_scheduler.md
Name: bar_move_scheduler

Overview:
- Sits between the PS/2 keyboard front end (scancode plus release flag) and the paddle position datapath.
- Tracks held keys for the left and right bars from make/break events.
- On each frame tick, snapshots the held keys and arbitrates the single shared position-update port between the two bars. Arbitration is round-robin, with a valid/ready handshake carrying one move step per transaction.

Parameters:
- TICK_DIV, 833333, clk cycles per move tick (50 MHz / 60 Hz)
- CNT_W, 20, tick counter width; must satisfy 2^CNT_W >= TICK_DIV
- L_UP, 8'h1D, left-bar up scancode
- L_DN, 8'h1B, left-bar down scancode
- L_LT, 8'h1C, left-bar left scancode
- L_RT, 8'h23, left-bar right scancode
- R_UP, 8'd146, right-bar up scancode
- R_DN, 8'd147, right-bar down scancode
- R_LT, 8'd145, right-bar left scancode
- R_RT, 8'd144, right-bar right scancode
- HOLD_TO, 6, ticks without a make code before a held key self-clears (used only with HOLD_TIMEOUT_EN)

Ports:
- clk  in  1  system clock (50 MHz domain)
- rst  in  1  asynchronous, active-high reset
- code_valid  in  1  one-cycle strobe: scancode/released valid
- scancode  in  8  key code
- released  in  1  1 = break event, 0 = make event
- upd_valid  out  1  update request to the position datapath
- upd_ready  in  1  datapath accepts the update
- upd_player  out  1  0 = left bar, 1 = right bar
- upd_dir  out  2  00 up, 01 down, 10 left, 11 right
- held_l  out  4  left held bitmap [3]up [2]down [1]left [0]right
- held_r  out  4  right held bitmap, same bit order
- overrun  out  1  sticky: a tick arrived while a burst was still issuing

Behaviour:
- Reset (asynchronous, any time, including mid-handshake):
  - All outputs 0; FSM goes to IDLE; pending masks 0; tick counter 0.
  - Round-robin pointer rr = 0 (left has priority first).
- Held bitmaps:
  - On code_valid with scancode equal to a key parameter, the matching bit is set if released=0 and cleared if released=1.
  - Unmatched codes are ignored.
  - Bitmaps update the cycle after the strobe.
- Tick:
  - Counter runs 0..TICK_DIV-1 and wraps.
  - tick is an internal one-cycle pulse on the wrap.
- Snapshot (on tick while in IDLE):
  - pend_l <= held_l, pend_r <= held_r.
  - Opposing pairs (up and down both set, or left and right both set) are removed from the snapshot as pairs.
  - If both masks are then 0, stay in IDLE; otherwise enter ISSUE on the next cycle.
- FSM:
  - IDLE -> ISSUE on tick with a nonzero snapshot.
  - ISSUE -> IDLE when the last pending bit is accepted.
- ISSUE:
  - upd_valid is registered and goes high the cycle after the tick (latency 1).
  - Selected player: rr if its mask is nonzero, otherwise the other player.
  - Selected direction: lowest-numbered code with a pending bit (up > down > left > right).
  - upd_player and upd_dir hold stable while upd_valid=1 and upd_ready=0.
- Accept (upd_valid & upd_ready):
  - Clear the selected pending bit.
  - rr <= ~upd_player.
  - Next selection is presented the following cycle.
  - upd_valid deasserts for one cycle only when returning to IDLE.
  - Back-to-back accepts are allowed: with upd_ready held at 1, upd_valid stays high continuously.
- Key changes during ISSUE update held_* only; the pending snapshot is not altered.
- Tick during ISSUE: tick is ignored (no re-snapshot), overrun <= 1. overrun clears only on rst.
- Simultaneous tick and final accept: the accept completes and the FSM returns to IDLE. The tick still counts as an overrun and is not snapshotted.
- Maximum burst per tick: 4 transactions (2 per player after pair cancellation).

Optional Feature:
- Macro: HOLD_TIMEOUT_EN.
- Defined:
  - Each of the 8 held bits has a tick-based age counter (width clog2(HOLD_TO+1)).
  - A make event for the key resets its counter to 0.
  - Each tick increments the counter of every set bit.
  - When a counter reaches HOLD_TO, the bit clears. This guards against lost break codes; typematic repeat refreshes held keys.
- Not defined: no counters; bits clear only on break events or rst.

Test Plan:
- TICK_DIV=16 for all tests.
- Reset mid-handshake: held_r=4'b1000, assert rst while upd_valid=1 -> all outputs 0 immediately; after release, no upd_valid until a new make event and a tick.
- Make 146 (released=0), upd_ready=1 -> at the next tick, one transaction: player=1, dir=00. Then break 146 -> held_r=0 and no further updates.
- Hold L_UP and R_RT, upd_ready=1 -> per tick, transactions (0,00) then (1,11). Same order on the following tick; upd_valid is high for exactly 2 consecutive cycles.
- Hold L_UP and L_DN -> cancelled pair, no updates. Hold L_UP, L_DN and L_LT -> only (0,10) is issued.
- upd_ready=0 held for 40 cycles with held_l=4'b0001 -> upd_valid and fields stay stable; overrun=1 after the next wrap; one accept once upd_ready rises.
- With HOLD_TIMEOUT_EN and HOLD_TO=6: make 8'h1D, no break -> held_l[3] clears at the 6th tick. A repeat make at tick 4 delays clearing to tick 10.
